// File: rtl/mstslv_cmd_arbiter_if.sv
// Handshake bundle between two command requesters, the arbiter, the datapath
// completion strobe and the custom_master_slave register port.
interface mstslv_cmd_arbiter_if;
  logic        req0;
  logic        req1;
  logic        req0_op;
  logic        req1_op;
  logic [25:0] req0_addr;
  logic [25:0] req1_addr;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic [15:0] req0_len;
  logic [15:0] req1_len;
  logic        xfer_done;
  logic [1:0]  gnt;
  logic        done0;
  logic        done1;
  logic        err;
  logic        busy;
  logic        slave_chipselect;
  logic        slave_write;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;

  modport master (
    input  req0, req1, req0_op, req1_op, req0_addr, req1_addr,
           req0_data, req1_data, req0_len, req1_len, xfer_done,
    output gnt, done0, done1, err, busy,
           slave_chipselect, slave_write, slave_address, slave_writedata
  );

  modport slave (
    output req0, req1, req0_op, req1_op, req0_addr, req1_addr,
           req0_data, req1_data, req0_len, req1_len, xfer_done,
    input  gnt, done0, done1, err, busy,
           slave_chipselect, slave_write, slave_address, slave_writedata
  );
endinterface

// File: rtl/mstslv_cmd_arbiter.sv
// Round-robin arbiter for two command requesters: programs the winner's command
// into four slave registers, then waits for datapath completion or timeout.
module mstslv_cmd_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input logic                  clk,
  input logic                  reset_n,
  mstslv_cmd_arbiter_if.master bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          err_q, err_d;
  logic          op_q, op_d;
  logic [25:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   len_q, len_d;
  logic          win_s;
  logic          in_reg_s;

  function automatic logic [31:0] reg_word(input logic [1:0] i, input logic op,
                                           input logic [25:0] addr,
                                           input logic [31:0] data,
                                           input logic [15:0] len);
    case (i)
      2'd0:    reg_word = {31'd0, op};
      2'd1:    reg_word = {6'd0, addr};
      2'd2:    reg_word = data;
      2'd3:    reg_word = {16'd0, len};
      default: reg_word = 32'd0;
    endcase
  endfunction

  // State and captured-command registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= 26'd0;
      data_q  <= 32'd0;
      len_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic: arbitration, register sequencing and completion wait.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    // With both requesting, the one not granted last wins; otherwise req1 alone picks 1.
    win_s   = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d  = win_s ? 2'b10 : 2'b01;
          op_d   = win_s ? bus.req1_op   : bus.req0_op;
          addr_d = win_s ? bus.req1_addr : bus.req0_addr;
          data_d = win_s ? bus.req1_data : bus.req0_data;
          len_d  = win_s ? bus.req1_len  : bus.req0_len;
          idx_d  = 2'd0;
          cnt_d  = '0;
          err_d  = 1'b0;
          if ((win_s ? bus.req1_len : bus.req0_len) == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: begin
        if (idx_q == 2'd3) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SETUP;
        end
      end
      ST_WAIT: begin
        if (bus.xfer_done) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = gnt_q[1];
        gnt_d   = 2'b00;
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_reg_s             = (state_q == ST_SETUP) || (state_q == ST_WRITE);
  assign bus.slave_chipselect = in_reg_s;
  assign bus.slave_write      = (state_q == ST_WRITE);
  assign bus.slave_address    = in_reg_s ? {1'b0, idx_q} : 3'd0;
  assign bus.slave_writedata  = in_reg_s ? reg_word(idx_q, op_q, addr_q, data_q, len_q) : 32'd0;
  assign bus.gnt              = gnt_q;
  assign bus.done0            = (state_q == ST_DONE) && gnt_q[0];
  assign bus.done1            = (state_q == ST_DONE) && gnt_q[1];
  assign bus.err              = (state_q == ST_DONE) && err_q;
  assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mstslv_cmd_arbiter.sv
// Directed self-checking bench for mstslv_cmd_arbiter; inputs change and
// outputs are sampled on the falling clock edge.
module tb_mstslv_cmd_arbiter;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset_n;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  logic [10:0] ctl_s;

  mstslv_cmd_arbiter_if bus ();

  mstslv_cmd_arbiter #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign ctl_s = {bus.gnt, bus.done0, bus.done1, bus.err, bus.busy,
                  bus.slave_chipselect, bus.slave_write, bus.slave_address};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0;       bus.req1 = 1'b0;
    bus.req0_op = 1'b0;    bus.req1_op = 1'b0;
    bus.req0_addr = 26'd0; bus.req1_addr = 26'd0;
    bus.req0_data = 32'd0; bus.req1_data = 32'd0;
    bus.req0_len = 16'd0;  bus.req1_len = 16'd0;
    bus.xfer_done = 1'b0;
  endtask

  initial begin
    logic [31:0] w1 [4];
    int n;
    w1[0] = 32'd1; w1[1] = 32'd584; w1[2] = 32'd0; w1[3] = 32'd22;

    // reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req0 = 1'($urandom);      bus.req1 = 1'($urandom);
      bus.req0_op = 1'($urandom);   bus.req1_op = 1'($urandom);
      bus.req0_addr = 26'($urandom); bus.req1_addr = 26'($urandom);
      bus.req0_data = $urandom;     bus.req1_data = $urandom;
      bus.req0_len = 16'($urandom); bus.req1_len = 16'($urandom);
      bus.xfer_done = 1'($urandom);
      @(negedge clk);
      check_eq("rst_ctl", 32'(ctl_s), 32'd0);
      check_eq("rst_wd", bus.slave_writedata, 32'd0);
    end
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_busy", 32'(bus.busy), 32'd0);

    // single request from requester 0
    bus.req0 = 1'b1; bus.req0_op = 1'b1; bus.req0_addr = 26'd584;
    bus.req0_data = 32'd0; bus.req0_len = 16'd22;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t1_cs",   32'(bus.slave_chipselect), 32'd1);
      check_eq("t1_wr",   32'(bus.slave_write), 32'(i % 2));
      check_eq("t1_addr", 32'(bus.slave_address), 32'(i / 2));
      check_eq("t1_wd",   bus.slave_writedata, w1[i / 2]);
      check_eq("t1_gnt",  32'(bus.gnt), 32'd1);
      bus.req0_addr = (i == 1) ? 26'h3ffffff : bus.req0_addr;
      bus.xfer_done = (i == 2) ? 1'b1 : 1'b0;
    end
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      check_eq("t1_wait", 32'(ctl_s), {21'd0, 2'b01, 4'b0001, 5'd0});
      bus.xfer_done = (w == 5) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    bus.xfer_done = 1'b0;
    check_eq("t1_done", 32'({bus.gnt, bus.done1, bus.done0, bus.err}), 32'b01010);
    bus.req0 = 1'b0;
    @(negedge clk);
    check_eq("t1_idle", 32'(ctl_s), 32'd0);
    @(negedge clk);
    check_eq("t1_once", 32'(bus.done0), 32'd0);

    // contention: both requests held from reset
    reset_n = 1'b0;
    bus.req0 = 1'b1; bus.req0_len = 16'd4;
    bus.req1 = 1'b1; bus.req1_len = 16'd4;
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n = 0;
      while (bus.gnt == 2'b00 && n < 4) begin
        @(negedge clk);
        n++;
      end
      check_eq("t2_gap", 32'(n), 32'd0);
      check_eq("t2_gnt", 32'(bus.gnt), (t % 2 == 1) ? 32'd2 : 32'd1);
      repeat (8) @(negedge clk);
      check_eq("t2_wait", 32'({bus.busy, bus.slave_chipselect}), 32'b10);
      bus.xfer_done = 1'b1;
      @(negedge clk);
      bus.xfer_done = 1'b0;
      check_eq("t2_done", 32'({bus.done1, bus.done0}), (t % 2 == 1) ? 32'd2 : 32'd1);
      check_eq("t2_oh", 32'($onehot0(bus.gnt)), 32'd1);
      if (t % 2 == 1) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      @(negedge clk);
      check_eq("t2_idle", 32'(bus.gnt), 32'd0);
      if (t < 3) begin
        if (t % 2 == 1) bus.req1 = 1'b1; else bus.req0 = 1'b1;
      end else begin
        bus.req0 = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("t2_end", 32'(bus.busy), 32'd0);

    // zero-length request from requester 1
    bus.req1 = 1'b1; bus.req1_len = 16'd0;
    @(negedge clk);
    check_eq("t3_done", 32'(ctl_s), {21'd0, 2'b10, 4'b0101, 5'd0});
    bus.req1 = 1'b0;
    @(negedge clk);
    check_eq("t3_idle", 32'(ctl_s), 32'd0);

    // timeout with a late completion strobe
    bus.req0 = 1'b1; bus.req0_len = 16'd5;
    repeat (8) @(negedge clk);
    check_eq("t4_lastwr", 32'({bus.slave_write, bus.slave_address}), 32'b1011);
    for (int w = 0; w < TO; w++) begin
      @(negedge clk);
      if (w == TO - 1) check_eq("t4_pre", 32'(ctl_s), {21'd0, 2'b01, 4'b0001, 5'd0});
    end
    @(negedge clk);
    check_eq("t4_to", 32'({bus.done0, bus.err}), 32'b11);
    bus.req0 = 1'b0;
    bus.xfer_done = 1'b1;
    @(negedge clk);
    bus.xfer_done = 1'b0;
    check_eq("t4_late", 32'(ctl_s), 32'd0);
    @(negedge clk);
    check_eq("t4_idle", 32'(ctl_s), 32'd0);

    // reset during the write of register 2
    bus.req0 = 1'b1; bus.req0_op = 1'b1; bus.req0_len = 16'd3;
    repeat (6) @(negedge clk);
    check_eq("t5_wr2", 32'({bus.slave_write, bus.slave_address}), 32'b1010);
    #2 reset_n = 1'b0;
    #1 check_eq("t5_async", 32'(ctl_s), 32'd0);
    @(negedge clk);
    check_eq("t5_hold", 32'(ctl_s), 32'd0);
    bus.req0 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t5_rel", 32'(ctl_s), 32'd0);
    bus.req0 = 1'b1;
    @(negedge clk);
    check_eq("t5_restart", 32'(ctl_s), {21'd0, 2'b01, 4'b0001, 2'b10, 3'd0});
    check_eq("t5_wd0", bus.slave_writedata, 32'd1);
    @(negedge clk);
    check_eq("t5_wr0", 32'({bus.slave_write, bus.slave_address}), 32'b1000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
